// File: rtl/prog_mem_pkg.sv
// Shared definitions for the prog_mem instruction memory.
// Holds the loader/fetch state enum, the header magic value and the
// default geometry of the memory (4 words x 4 bits, 2-bit address).
package prog_mem_pkg;

    localparam int DEF_WORDS  = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_WIDTH  = 4;

    // Upper two bits of a valid header nibble.
    localparam logic [1:0] HDR_MAGIC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_e;

endpackage

// File: rtl/prog_mem_if.sv
// Bus bundle between prog_mem and its two clients: the nibble loader
// (start, ld_valid, ld_data, ld_ready) and the CPU core's fetch/reset side
// (rom_addr, rom_value, core_run), plus the busy/error status flags.
//   master : loader + core side (drives start, ld_valid, ld_data, rom_addr)
//   slave  : prog_mem side (drives ld_ready, rom_value, core_run, busy, error)
interface prog_mem_if #(
    parameter int ADDR_W = prog_mem_pkg::DEF_ADDR_W,
    parameter int WIDTH  = prog_mem_pkg::DEF_WIDTH
);
    logic              start;
    logic              ld_valid;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_value;
    logic              core_run;
    logic              busy;
    logic              error;

    modport master (
        output start, ld_valid, ld_data, rom_addr,
        input  ld_ready, rom_value, core_run, busy, error
    );

    modport slave (
        input  start, ld_valid, ld_data, rom_addr,
        output ld_ready, rom_value, core_run, busy, error
    );
endinterface

// File: rtl/prog_mem_array.sv
// Storage array for prog_mem: WORDS x WIDTH flops.
// Ports:
//   clock, reset     - clock and asynchronous active-low clear
//   clr              - synchronous clear of every word (wins over a write)
//   we, waddr, wdata - single write port
//   raddr, rdata     - combinational read port (zero-cycle latency)
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int WORDS  = DEF_WORDS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WORDS-1:0][WIDTH-1:0] mem_q;
    logic [WORDS-1:0][WIDTH-1:0] mem_d;

    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        mem_d = mem_q;
        if (clr) begin
            mem_d = '0;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this memory is a handful of flops, so it takes the async reset
    // like any other register; a large RAM macro could not be cleared this way.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem.sv
// Writable instruction memory for the CPU core.
// A loader streams nibbles (header, N data words, checksum) over a
// valid/ready handshake; once the checksum matches, the memory is exposed
// on the fetch port and the core is released from reset via core_run.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset (clears FSM, memory, core_run)
//   bus   - prog_mem_if slave: loader stream, fetch port, status flags
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int WORDS  = DEF_WORDS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    prog_mem_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;     // next data word to be written
    logic [ADDR_W-1:0] last_q, last_d;   // N-1 from the header
    logic [WIDTH-1:0]  sum_q, sum_d;     // running checksum, wraps mod 2**WIDTH
    logic              core_run_q, core_run_d;

    logic              ld_ready;
    logic              accept;
    logic              mem_clr;
    logic              mem_we;
    logic [WIDTH-1:0]  rd_data;

    assign ld_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    // start outranks any nibble presented in the same cycle.
    assign accept   = bus.ld_valid && ld_ready && !bus.start;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        sum_d   = sum_q;
        mem_clr = 1'b0;
        mem_we  = 1'b0;

        if (bus.start) begin
            state_d = ST_HDR;
            idx_d   = '0;
            sum_d   = '0;
            mem_clr = 1'b1;
        end else if (accept) begin
            unique case (state_q)
                ST_HDR: begin
                    if (bus.ld_data[WIDTH-1 -: 2] == HDR_MAGIC) begin
                        last_d  = bus.ld_data[ADDR_W-1:0];
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_DATA: begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + bus.ld_data;
                    if (idx_q == last_q) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
                ST_CHK: begin
                    state_d = (bus.ld_data == sum_q) ? ST_RUN : ST_ERR;
                end
                default: ;
            endcase
        end

        // Follows RUN one edge late and drops on the same edge start leaves RUN.
        core_run_d = (state_q == ST_RUN) && !bus.start;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            sum_q      <= '0;
            core_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            sum_q      <= sum_d;
            core_run_q <= core_run_d;
        end
    end

    prog_mem_array #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .clr   (mem_clr),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (bus.ld_data),
        .raddr (bus.rom_addr),
        .rdata (rd_data)
    );

    assign bus.ld_ready  = ld_ready;
    assign bus.busy      = ld_ready;
    assign bus.error     = (state_q == ST_ERR);
    assign bus.rom_value = (state_q == ST_RUN) ? rd_data : '0;
    assign bus.core_run  = core_run_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: a table of directed loads, hand-written
// reset/start corner cases, and randomized loads checked against a
// load-level reference model.
module tb_prog_mem;
    import prog_mem_pkg::*;

    localparam int PERIOD = 10;

    typedef logic [3:0][3:0] words_t;   // [i] = word i

    typedef struct packed {
        logic [3:0] hdr;
        words_t     data;
        logic [3:0] chk;
    } load_t;

    typedef struct packed {
        load_t  ld;
        logic   exp_run;
        words_t exp_rom;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #(PERIOD / 2) clock = ~clock;

    prog_mem_if #(.ADDR_W(DEF_ADDR_W), .WIDTH(DEF_WIDTH)) bus ();

    prog_mem #(
        .WORDS  (DEF_WORDS),
        .ADDR_W (DEF_ADDR_W),
        .WIDTH  (DEF_WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", bus.busy, 8'd1);
        check("start_error_clear", bus.error, 8'd0);
        check("start_core_run", bus.core_run, 8'd0);
    endtask

    // Offer one nibble after 'gap' idle cycles and hold it until accepted.
    task automatic send(input logic [3:0] d, input int gap);
        int waited;
        waited = 0;
        bus.ld_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.ld_data = 4'($urandom);
            tick();
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        while (!bus.ld_ready && waited < 16) begin
            tick();
            waited++;
        end
        if (!bus.ld_ready) begin
            check("ld_ready_timeout", bus.ld_ready, 8'd1);
            bus.ld_valid = 1'b0;
            return;
        end
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_data  = 4'($urandom);
    endtask

    task automatic do_load(input load_t l, input int gap_max);
        int n;
        n = int'(l.hdr[1:0]) + 1;
        pulse_start();
        send(l.hdr, $urandom_range(gap_max, 0));
        if (l.hdr[3:2] == 2'b10) begin
            for (int i = 0; i < n; i++) send(l.data[i], $urandom_range(gap_max, 0));
            send(l.chk, $urandom_range(gap_max, 0));
        end
    endtask

    // Called right after the last accepted nibble of a load.
    task automatic verify(input string tag, input logic exp_run, input words_t exp_rom);
        check({tag, "_core_run_first"}, bus.core_run, 8'd0);
        check({tag, "_error"}, bus.error, {7'd0, !exp_run});
        check({tag, "_ld_ready"}, bus.ld_ready, 8'd0);
        check({tag, "_busy"}, bus.busy, 8'd0);
        for (int a = 0; a < 4; a++) begin
            bus.rom_addr = 2'(a);
            #1;
            check($sformatf("%s_rom%0d", tag, a), bus.rom_value, exp_rom[a]);
        end
        tick();
        check({tag, "_core_run"}, bus.core_run, {7'd0, exp_run});
    endtask

    // Reference: the outcome of a whole load from the header/data/checksum rules.
    function automatic void model(input load_t l, output logic run, output words_t rom);
        int n;
        int sum;
        n   = int'(l.hdr[1:0]) + 1;
        sum = 0;
        rom = '0;
        for (int i = 0; i < n; i++) sum += int'(l.data[i]);
        run = (l.hdr[3:2] == 2'b10) && (int'(l.chk) == sum % 16);
        if (run) begin
            for (int i = 0; i < n; i++) rom[i] = l.data[i];
        end
    endfunction

    vec_t vecs [5];

    initial begin
        words_t full_rom;
        time    t0;
        load_t  rl;
        logic   exp_run;
        words_t exp_rom;

        vecs[0] = '{ld: '{hdr: 4'b1011, data: {4'h4, 4'h3, 4'h2, 4'h1}, chk: 4'hA},
                    exp_run: 1'b1, exp_rom: {4'h4, 4'h3, 4'h2, 4'h1}};
        vecs[1] = '{ld: '{hdr: 4'b1001, data: {4'h0, 4'h0, 4'hF, 4'h8}, chk: 4'h7},
                    exp_run: 1'b1, exp_rom: {4'h0, 4'h0, 4'hF, 4'h8}};
        vecs[2] = '{ld: '{hdr: 4'b0110, data: {4'h1, 4'h2, 4'h3, 4'h4}, chk: 4'h0},
                    exp_run: 1'b0, exp_rom: '0};
        vecs[3] = '{ld: '{hdr: 4'b1000, data: {4'h0, 4'h0, 4'h0, 4'h5}, chk: 4'h6},
                    exp_run: 1'b0, exp_rom: '0};
        vecs[4] = '{ld: '{hdr: 4'b1000, data: {4'h0, 4'h0, 4'h0, 4'h5}, chk: 4'h5},
                    exp_run: 1'b1, exp_rom: {4'h0, 4'h0, 4'h0, 4'h5}};
        full_rom = {4'h4, 4'h3, 4'h2, 4'h1};

        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.rom_addr = '0;
        reset        = 1'b0;
        #3;
        check("rst_ld_ready", bus.ld_ready, 8'd0);
        check("rst_busy", bus.busy, 8'd0);
        check("rst_error", bus.error, 8'd0);
        check("rst_core_run", bus.core_run, 8'd0);
        check("rst_rom_value", bus.rom_value, 8'd0);
        tick();
        #3 reset = 1'b1;
        tick();
        check("idle_ld_ready", bus.ld_ready, 8'd0);

        // Directed table; vector 0 runs gap-free to time start -> core_run.
        for (int i = 0; i < 5; i++) begin
            t0 = $time;
            do_load(vecs[i].ld, (i == 0) ? 0 : 2);
            verify($sformatf("vec%0d", i), vecs[i].exp_run, vecs[i].exp_rom);
            if (i == 0) check("start_to_run_cycles", 8'((($time - t0) / PERIOD)), 8'd8);
        end

        // Reset mid-DATA after 2 of 4 words.
        pulse_start();
        send(4'b1011, 0);
        send(4'h1, 0);
        send(4'h2, 0);
        bus.rom_addr = 2'd0;
        #1;
        check("data_rom_gated", bus.rom_value, 8'd0);
        check("data_busy", bus.busy, 8'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 8'd0);
        check("midrst_ld_ready", bus.ld_ready, 8'd0);
        check("midrst_error", bus.error, 8'd0);
        check("midrst_core_run", bus.core_run, 8'd0);
        check("midrst_rom", bus.rom_value, 8'd0);
        tick();
        #3 reset = 1'b1;
        tick();
        check("post_rst_idle_busy", bus.busy, 8'd0);
        do_load(vecs[0].ld, 1);
        verify("after_rst", 1'b1, full_rom);

        // Reset while running drops core_run and the fetch port at once.
        bus.rom_addr = 2'd3;
        #2 reset = 1'b0;
        #1;
        check("runrst_core_run", bus.core_run, 8'd0);
        check("runrst_rom", bus.rom_value, 8'd0);
        tick();
        #3 reset = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 4'b1011;
        tick();
        tick();
        check("idle_ignores_valid", bus.busy, 8'd0);
        bus.ld_valid = 1'b0;

        // start coinciding with a valid nibble in DATA.
        pulse_start();
        send(4'b1011, 0);
        send(4'h7, 0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 4'h9;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        check("collide_ld_ready", bus.ld_ready, 8'd1);
        check("collide_error", bus.error, 8'd0);
        send(4'b1000, 0);
        send(4'h0, 0);
        send(4'h0, 0);
        verify("collide", 1'b1, '0);

        // Randomized loads against the reference model.
        for (int r = 0; r < 30; r++) begin
            int n;
            int sum;
            rl.hdr[1:0] = 2'($urandom);
            rl.hdr[3:2] = ($urandom_range(7, 0) != 0) ? 2'b10 : 2'($urandom);
            rl.data     = words_t'($urandom);
            n   = int'(rl.hdr[1:0]) + 1;
            sum = 0;
            for (int i = 0; i < n; i++) sum += int'(rl.data[i]);
            rl.chk = ($urandom_range(2, 0) != 0) ? 4'(sum) : 4'($urandom);
            model(rl, exp_run, exp_rom);
            do_load(rl, 3);
            verify($sformatf("rnd%0d", r), exp_run, exp_rom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
